controle_multiciclo: RTL

- Multi-cycle control unit for the 8-bit nRisc datapath.
- Sequences each instruction through fetch, decode, execute, memory and write-back states.
- Drives the 2-bit `ULAOp` code, mux selects and write enables that the ALU and datapath consume.
- Reads back the ALU `zero` flag to resolve branches, and handshakes with the unified instruction/data memory through `mem_pronto`.

---
 rtl/controle_multiciclo.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/controle_multiciclo.sv
// ============================================================================
//  Module      : controle_multiciclo
//  Description : Multi-cycle control unit for the 8-bit nRisc datapath.
//                Moore/Mealy decode of the state register drives the datapath.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module controle_multiciclo (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] instrucao,
    input  logic       zero,
    input  logic       mem_pronto,
    output logic [1:0] ULAOp,
    output logic       ula_fonte_a,
    output logic [1:0] ula_fonte_b,
    output logic [1:0] pc_fonte,
    output logic       escreve_pc,
    output logic       escreve_ir,
    output logic       iord,
    output logic       le_mem,
    output logic       escreve_mem,
    output logic       escreve_reg,
    output logic       mem_para_reg,
    output logic [3:0] estado
);

    typedef enum logic [3:0] {
        BUSCA       = 4'd0,
        DECODIFICA  = 4'd1,
        EXECUTA     = 4'd2,
        ESCRITA_ULA = 4'd3,
        ENDERECO    = 4'd4,
        ACESSO_MEM  = 4'd5,
        ESCRITA_MEM = 4'd6,
        DESVIO      = 4'd7,
        SALTO       = 4'd8
    } estado_t;

    localparam logic [2:0] c_OP_ADD  = 3'b000;
    localparam logic [2:0] c_OP_SUB  = 3'b001;
    localparam logic [2:0] c_OP_SLT  = 3'b010;
    localparam logic [2:0] c_OP_ADDI = 3'b011;
    localparam logic [2:0] c_OP_LW   = 3'b100;
    localparam logic [2:0] c_OP_SW   = 3'b101;
    localparam logic [2:0] c_OP_BEQ  = 3'b110;

    localparam logic [1:0] c_ULA_ADD = 2'b00;
    localparam logic [1:0] c_ULA_SUB = 2'b01;
    localparam logic [1:0] c_ULA_SLT = 2'b10;

    localparam logic [1:0] c_B_REG   = 2'b00;
    localparam logic [1:0] c_B_UM    = 2'b01;
    localparam logic [1:0] c_B_IMED  = 2'b10;
    localparam logic [1:0] c_B_DESV  = 2'b11;

    estado_t    r_estado;
    estado_t    w_proximo;
    logic [2:0] w_opcode;
    logic       w_unused;

    assign w_opcode = instrucao[7:5];
    assign w_unused = &{1'b0, instrucao[4:0]};
    assign estado   = r_estado;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado <= BUSCA;
        end else begin
            r_estado <= w_proximo;
        end
    end

    always_comb begin
        w_proximo    = BUSCA;
        ULAOp        = c_ULA_ADD;
        ula_fonte_a  = 1'b0;
        ula_fonte_b  = c_B_REG;
        pc_fonte     = 2'b00;
        escreve_pc   = 1'b0;
        escreve_ir   = 1'b0;
        iord         = 1'b0;
        le_mem       = 1'b0;
        escreve_mem  = 1'b0;
        escreve_reg  = 1'b0;
        mem_para_reg = 1'b0;

        // Outputs are forced low for the whole time reset is high, not just on the edge.
        if (!reset) begin
            case (r_estado)
                BUSCA: begin
                    le_mem      = 1'b1;
                    ula_fonte_b = c_B_UM;
                    if (mem_pronto) begin
                        escreve_ir = 1'b1;
                        escreve_pc = 1'b1;
                        w_proximo  = DECODIFICA;
                    end else begin
                        w_proximo  = BUSCA;
                    end
                end

                DECODIFICA: begin
                    ula_fonte_b = c_B_DESV;
                    case (w_opcode)
                        c_OP_LW, c_OP_SW: w_proximo = ENDERECO;
                        c_OP_BEQ:         w_proximo = DESVIO;
                        c_OP_ADD, c_OP_SUB, c_OP_SLT, c_OP_ADDI:
                                          w_proximo = EXECUTA;
                        default:          w_proximo = SALTO;
                    endcase
                end

                EXECUTA: begin
                    ula_fonte_a = 1'b1;
                    case (w_opcode)
                        c_OP_SUB: ULAOp = c_ULA_SUB;
                        c_OP_SLT: ULAOp = c_ULA_SLT;
                        default:  ULAOp = c_ULA_ADD;
                    endcase
                    ula_fonte_b = (w_opcode == c_OP_ADDI) ? c_B_IMED : c_B_REG;
                    w_proximo   = ESCRITA_ULA;
                end

                ESCRITA_ULA: begin
                    escreve_reg = 1'b1;
                    w_proximo   = BUSCA;
                end

                ENDERECO: begin
                    ula_fonte_a = 1'b1;
                    ula_fonte_b = c_B_IMED;
                    w_proximo   = ACESSO_MEM;
                end

                ACESSO_MEM: begin
                    iord = 1'b1;
                    if (w_opcode == c_OP_SW) begin
                        escreve_mem = 1'b1;
                    end else begin
                        le_mem      = 1'b1;
                    end
                    if (!mem_pronto) begin
                        w_proximo = ACESSO_MEM;
                    end else if (w_opcode == c_OP_SW) begin
                        w_proximo = BUSCA;
                    end else begin
                        w_proximo = ESCRITA_MEM;
                    end
                end

                ESCRITA_MEM: begin
                    escreve_reg  = 1'b1;
                    mem_para_reg = 1'b1;
                    w_proximo    = BUSCA;
                end

                DESVIO: begin
                    ula_fonte_a = 1'b1;
                    ULAOp       = c_ULA_SUB;
                    pc_fonte    = 2'b01;
                    escreve_pc  = zero;
                    w_proximo   = BUSCA;
                end

                SALTO: begin
                    escreve_pc = 1'b1;
                    pc_fonte   = 2'b10;
                    w_proximo  = BUSCA;
                end

                default: w_proximo = BUSCA;
            endcase
        end
    end

endmodule

`default_nettype wire
